// File: rtl/bytemem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bytemem_ctrl_pkg
// Shared types and helpers for the byte-memory controller:
//   - state_e : controller FSM state encoding
//   - port_e  : which requester owns the current transaction
//   - SZ_*    : access size encodings (10 and 11 both mean word)
//   - size_last() : size -> number of bytes minus one
//   - size_mask() : size -> zero-extension mask for read data
//   - byte_sel()  : pick byte lane k of a 32-bit store word
// -----------------------------------------------------------------------------
package bytemem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit positions of each requester in the arbiter request/grant vectors.
  localparam int IDX_IF = 0;
  localparam int IDX_D  = 1;

  function automatic logic [1:0] size_last(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      SZ_BYTE: r = 2'd0;
      SZ_HALF: r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    logic [31:0] m;
    case (sz)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bytemem_ctrl_if.sv
// -----------------------------------------------------------------------------
// bytemem_ctrl_if
// Bundles the fetch port, the data port and the byte-memory port of the
// controller.
//   slave  : the controller side (takes requests, drives the memory)
//   master : the environment side (requesters plus the memory read path)
// Signals:
//   if_req/if_addr -> if_rdata/if_ack        fetch (always 32-bit read)
//   d_req/d_wr/d_size/d_addr/d_wdata -> d_rdata/d_ack   data load/store
//   mem_addr/mem_wdata/mem_enable/mem_wr <- mem_rdata   memory port
// -----------------------------------------------------------------------------
interface bytemem_ctrl_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_addr, mem_wdata, mem_enable, mem_wr,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_addr, mem_wdata, mem_enable, mem_wr,
    output mem_rdata
  );

endinterface

// File: rtl/bytemem_ctrl_arb2_rr.sv
// -----------------------------------------------------------------------------
// arb2_rr
// Two-requester round-robin arbiter. Bit 0 is the fetch port, bit 1 the data
// port. On a tie the port that did not win last time is granted; after reset
// the data port wins the first tie. The pointer only moves when grant_en_i is
// high and a grant is actually issued.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   req_i[1:0]   : request vector
//   grant_en_i   : grants are only issued (and the pointer moved) when high
//   gnt_o[1:0]   : one-hot grant, combinational
// -----------------------------------------------------------------------------
module arb2_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] gnt_o
);

  // 1 = data port has priority on the next tie.
  logic prio_d_q;
  logic prio_d_d;

  // Grant resolution from requests and the priority pointer.
  always_comb begin
    gnt_o = 2'b00;
    if (grant_en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_d_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Next pointer: after a fetch grant the data port is favoured, and vice versa.
  always_comb begin
    prio_d_d = prio_d_q;
    if (gnt_o != 2'b00) begin
      prio_d_d = gnt_o[0];
    end else begin
      prio_d_d = prio_d_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_d_q <= 1'b1;
    end else begin
      prio_d_q <= prio_d_d;
    end
  end

endmodule

// File: rtl/bytemem_ctrl.sv
// -----------------------------------------------------------------------------
// bytemem_ctrl
// Shares a byte-write / word-read memory between a fetch port and a data
// port. Stores are split into consecutive single-byte writes; reads use the
// memory's 32-bit combinational read path and are registered before return.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : bytemem_ctrl_if.slave (fetch port, data port, memory port)
// All outputs on bus are driven straight from registers. The memory signals
// for a given cycle are therefore computed one cycle early, from the next
// state, so that they line up with READ/WRITE.
// -----------------------------------------------------------------------------
module bytemem_ctrl
  import bytemem_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bytemem_ctrl_if.slave bus
);

  state_e      state_q,     state_d;
  logic [1:0]  cnt_q,       cnt_d;
  port_e       port_q,      port_d;
  logic [31:0] addr_q,      addr_d;
  logic [1:0]  size_q,      size_d;
  logic        wr_q,        wr_d;
  logic [31:0] wdata_q,     wdata_d;

  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;
  logic        if_ack_q,    if_ack_d;
  logic        d_ack_q,     d_ack_d;

  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_en_q,    mem_en_d;
  logic        mem_wr_q,    mem_wr_d;

  logic [1:0]  req_s;
  logic [1:0]  gnt_s;
  logic        grant_en_s;

  assign req_s      = {bus.d_req, bus.if_req};
  assign grant_en_s = (state_q == IDLE);

  arb2_rr u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_s),
    .grant_en_i (grant_en_s),
    .gnt_o      (gnt_s)
  );

  // FSM next state, transaction latch, read capture and next memory drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    mem_addr_d  = 32'h0000_0000;
    mem_wdata_d = 8'h00;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          if (gnt_s[IDX_D]) begin
            port_d  = PORT_D;
            addr_d  = bus.d_addr;
            size_d  = bus.d_size;
            wr_d    = bus.d_wr;
            wdata_d = bus.d_wdata;
          end else begin
            port_d  = PORT_IF;
            addr_d  = bus.if_addr;
            size_d  = SZ_WORD;
            wr_d    = 1'b0;
            wdata_d = 32'h0000_0000;
          end
          cnt_d       = 2'd0;
          state_d     = wr_d ? WRITE : READ;
          // First memory cycle is driven straight from the freshly latched request.
          mem_en_d    = 1'b1;
          mem_wr_d    = wr_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wr_d ? wdata_d[7:0] : 8'h00;
        end else begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (port_q == PORT_D) begin
          d_rdata_d = bus.mem_rdata & size_mask(size_q);
          d_ack_d   = 1'b1;
        end else begin
          if_rdata_d = bus.mem_rdata & size_mask(size_q);
          if_ack_d   = 1'b1;
        end
        state_d = DONE;
      end

      WRITE: begin
        if (cnt_q == size_last(size_q)) begin
          state_d = DONE;
          cnt_d   = 2'd0;
          if (port_q == PORT_D) begin
            d_ack_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
          end
        end else begin
          // Next byte: address wraps naturally at 2^32.
          cnt_d       = cnt_q + 2'd1;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = addr_q + {30'd0, cnt_d};
          mem_wdata_d = byte_sel(wdata_q, cnt_d);
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State, transaction and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      port_q      <= PORT_D;
      addr_q      <= 32'h0000_0000;
      size_q      <= SZ_BYTE;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      if_rdata_q  <= 32'h0000_0000;
      d_rdata_q   <= 32'h0000_0000;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 8'h00;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_enable = mem_en_q;
  assign bus.mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_bytemem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bytemem_ctrl
// Table of single transactions with hand-computed results, followed by
// hand-written sequences: reset during a word store, continuous contention,
// and a request held past its ack. A 256-byte memory model (low address byte
// only) stands in for the byte memory.
// -----------------------------------------------------------------------------
module tb_bytemem_ctrl;
  import bytemem_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bytemem_ctrl_if bus ();

  bytemem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model
  logic [7:0]  mem [256];
  logic        mem_clr;
  logic [31:0] wl_addr[$];
  logic [7:0]  wl_data[$];
  int          wr_count;

  assign bus.mem_rdata = {mem[bus.mem_addr[7:0] + 8'd3], mem[bus.mem_addr[7:0] + 8'd2],
                          mem[bus.mem_addr[7:0] + 8'd1], mem[bus.mem_addr[7:0]]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_enable && bus.mem_wr) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wl_addr.push_back(bus.mem_addr);
      wl_data.push_back(bus.mem_wdata);
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        is_if;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ack"},   {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    chk({name, "_memctl"}, {30'd0, bus.mem_enable, bus.mem_wr}, 32'd0);
    chk({name, "_maddr"}, bus.mem_addr, 32'd0);
    chk({name, "_mwdata"}, {24'd0, bus.mem_wdata}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          edges;
    bit          got;
    int          nb;
    logic [31:0] prev_other;
    logic [31:0] ea;
    prev_other = v.is_if ? exp_d_rdata : exp_if_rdata;
    wl_addr.delete();
    wl_data.delete();
    @(negedge clk);
    if (v.is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_wr    = v.wr;
      bus.d_size  = v.size;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        chk($sformatf("v%0d_first_cycle", idx), {30'd0, bus.mem_enable, bus.mem_wr}, {30'd0, 1'b1, v.wr});
        chk($sformatf("v%0d_first_addr", idx), bus.mem_addr, v.addr);
        // Changes after the grant must be ignored.
        bus.if_addr = 32'hBAD0_0000;
        bus.d_addr  = 32'hBAD0_0000;
        bus.d_wdata = 32'hFFFF_FFFF;
        bus.d_size  = ~v.size;
      end
      if (bus.if_ack || bus.d_ack) got = 1'b1;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    chk($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.lat));
    chk($sformatf("v%0d_ack_port", idx), {30'd0, bus.if_ack, bus.d_ack},
        v.is_if ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_done_memctl", idx), {30'd0, bus.mem_enable, bus.mem_wr}, 32'd0);
    chk($sformatf("v%0d_done_maddr", idx), bus.mem_addr, 32'd0);
    if (!v.wr) begin
      if (v.is_if) begin
        chk($sformatf("v%0d_if_rdata", idx), bus.if_rdata, v.rdata);
        exp_if_rdata = v.rdata;
      end else begin
        chk($sformatf("v%0d_d_rdata", idx), bus.d_rdata, v.rdata);
        exp_d_rdata = v.rdata;
      end
    end
    chk($sformatf("v%0d_other_rdata", idx), v.is_if ? bus.d_rdata : bus.if_rdata, prev_other);
    nb = !v.wr ? 0 : (v.size == SZ_BYTE) ? 1 : (v.size == SZ_HALF) ? 2 : 4;
    chk($sformatf("v%0d_nwrites", idx), 32'(wl_addr.size()), 32'(nb));
    for (int k = 0; k < nb && k < wl_addr.size(); k++) begin
      ea = v.addr + 32'(k);
      chk($sformatf("v%0d_waddr%0d", idx, k), wl_addr[k], ea);
      chk($sformatf("v%0d_wdata%0d", idx, k), {24'd0, wl_data[k]}, {24'd0, v.wdata[8*k +: 8]});
    end
    @(negedge clk);
    chk($sformatf("v%0d_ack_pulse", idx), {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
  endtask

  initial begin
    int          edges;
    bit          got;
    int          wc0;
    logic [1:0]  eack;

    n_checks = 0;
    n_fail   = 0;
    wr_count = 0;
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'd0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
    mem_clr = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;

    //          is_if wr    size     addr          wdata          lat rdata
    vecs[0]  = '{1'b0, 1'b1, SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 5, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0010, 32'h0,         2, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, SZ_HALF, 32'h0000_0021, 32'hAAAA_1234, 3, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, SZ_BYTE, 32'h0000_0022, 32'h0,         2, 32'h0000_0012};
    vecs[4]  = '{1'b0, 1'b0, SZ_HALF, 32'h0000_0021, 32'h0,         2, 32'h0000_1234};
    vecs[5]  = '{1'b0, 1'b0, 2'b11,   32'h0000_0010, 32'h0,         2, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, SZ_BYTE, 32'h0000_0030, 32'hCCCC_CC55, 2, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, SZ_WORD, 32'hFFFF_FFFE, 32'h1122_3344, 5, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, SZ_WORD, 32'hFFFF_FFFE, 32'h0,         2, 32'h1122_3344};
    vecs[9]  = '{1'b0, 1'b0, SZ_BYTE, 32'h0000_0013, 32'h0,         2, 32'h0000_00DE};
    vecs[10] = '{1'b0, 1'b0, SZ_HALF, 32'h0000_0012, 32'h0,         2, 32'h0000_DEAD};
    vecs[11] = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0020, 32'h0,         2, 32'h0012_3400};
    vecs[12] = '{1'b0, 1'b1, 2'b11,   32'h0000_002C, 32'h0A0B_0C0D, 5, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_if_rdata", bus.if_rdata, 32'd0);
    chk("reset_d_rdata", bus.d_rdata, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset asserted mid word store: two bytes land, the rest never do.
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_size  = SZ_WORD;
    bus.d_addr  = 32'h0000_0040;
    bus.d_wdata = 32'h4433_2211;
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_all_zero("abort_now");
    chk("abort_d_rdata", bus.d_rdata, 32'd0);
    chk("abort_if_rdata", bus.if_rdata, 32'd0);
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    end
    chk("abort_mem40", {24'd0, mem[8'h40]}, 32'h11);
    chk("abort_mem41", {24'd0, mem[8'h41]}, 32'h22);
    chk("abort_mem42", {24'd0, mem[8'h42]}, 32'h00);
    chk("abort_mem43", {24'd0, mem[8'h43]}, 32'h00);
    rst = 1'b1;

    // Both ports requesting continuously: data, IF, data, IF.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_size  = SZ_HALF;
    bus.d_addr  = 32'h0000_0040;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      eack = (e == 2 || e == 8) ? 2'b01 : (e == 5 || e == 11) ? 2'b10 : 2'b00;
      chk($sformatf("rr_ack_e%0d", e), {30'd0, bus.if_ack, bus.d_ack}, {30'd0, eack});
      if (bus.mem_enable) chk($sformatf("rr_no_write_e%0d", e), {31'd0, bus.mem_wr}, 32'd0);
      if (eack == 2'b01) chk($sformatf("rr_d_rdata_e%0d", e), bus.d_rdata, 32'h0000_2211);
      if (eack == 2'b10) chk($sformatf("rr_if_rdata_e%0d", e), bus.if_rdata, 32'hDEAD_BEEF);
      if (e == 11) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      chk("rr_quiet", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    end

    // Request held one cycle past ack starts an identical second store.
    wc0 = wr_count;
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_size  = SZ_BYTE;
    bus.d_addr  = 32'h0000_0050;
    bus.d_wdata = 32'h0000_0077;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      got = bus.d_ack;
    end
    chk("hold_first_lat", 32'(edges), 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_ack", {31'd0, bus.d_ack}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    chk("hold_regrant", {30'd0, bus.mem_enable, bus.mem_wr}, 32'd3);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      got = bus.d_ack;
    end
    chk("hold_second_lat", 32'(edges), 32'd1);
    chk("hold_nwrites", 32'(wr_count - wc0), 32'd2);
    chk("hold_mem50", {24'd0, mem[8'h50]}, 32'h77);
    @(negedge clk);
    chk("hold_after", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bytemem_ctrl.md
# bytemem_ctrl

Sequencing controller and two-port arbiter in front of the byte-addressable `bytememory`. It shares the memory between the instruction-fetch port and the data port. Word and halfword stores are broken into back-to-back single-byte writes, since the memory writes one byte per clock. Reads use the memory's combinational 32-bit read port and are registered before being returned.

## Interface
- No parameters; addresses are fixed at 32 bits, memory data path at 8 bits write / 32 bits read.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request (always a 32-bit read).
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetch data, valid while `if_ack`=1.
- `if_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request.
- `d_wr` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 = byte, 01 = half, 10/11 = word.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, little-endian; byte k goes to `d_addr`+k.
- `d_rdata` out 32: load data, zero-extended, valid while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 8: memory write byte.
- `mem_enable` out 1: memory enable.
- `mem_wr` out 1: memory write strobe.
- `mem_rdata` in 32: {mem[a+3], mem[a+2], mem[a+1], mem[a]} for a = `mem_addr`.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE → READ or WRITE when any request is high.
  - READ → DONE.
  - WRITE → DONE after the last byte.
  - DONE → IDLE.
- Requests are sampled only in IDLE. On a grant the controller latches port, address, size, write flag and write data; later changes to the inputs are ignored.
- Arbitration uses a round-robin pointer.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - The pointer updates on each grant. After reset, the data port wins the first tie.
- READ:
  - Drives `mem_enable`=1, `mem_wr`=0, `mem_addr`=latched address.
  - Captures `mem_rdata` into the granted port's rdata register, masked by size: byte → [7:0], half → [15:0], word → all 32 bits; upper bits are 0.
- WRITE:
  - A byte counter `cnt` starts at 0.
  - Each cycle drives `mem_enable`=1, `mem_wr`=1, `mem_addr`=latched address+`cnt`, `mem_wdata`=`wdata[8*cnt+7:8*cnt]`.
  - Exits after `cnt` = nbytes−1, where nbytes = 1/2/4.
- Address arithmetic is modulo 2^32, so 0xFFFFFFFF+1 wraps to 0. No alignment checks are made.
- DONE: the granted port's ack is 1 for exactly this cycle. Its rdata holds the captured value; the other port's rdata is unchanged.
- Outside READ/WRITE: `mem_enable`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- A requester must drop `req` on the edge at which it sees ack. If `req` is still high in IDLE, it is a new request.

## Timing
- Reset values: state IDLE, `cnt`=0, both acks 0, both rdata 0, all `mem_*` outputs 0, pointer favours data.
- Reset is asynchronous. Asserting it mid-WRITE abandons the transaction; bytes already written stay in memory, and no ack is issued.
- Latency from the request-sampling edge (cycle 0, in IDLE) to ack:
  - Read (any size): READ in cycle 1, ack in cycle 2.
  - Byte store: ack in cycle 2.
  - Half store: ack in cycle 3.
  - Word store: ack in cycle 5.
- Back-to-back throughput:
  - Reads: one per 3 cycles (IDLE, READ, DONE).
  - Word stores: one per 6 cycles.
- The memory never sees a read and a write in the same cycle.
- If both ports request continuously, grants alternate. Neither port waits more than one transaction.

## Structure
- Package `bytemem_ctrl_pkg` holds:
  - the state encoding (IDLE/READ/WRITE/DONE);
  - the size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - a function mapping size to nbytes−1.
- Sub-module `arb2_rr`: two-requester round-robin arbiter with a registered last-grant pointer and a `grant_en` input. It contains the same clock and reset.
- The FSM, counter, byte mux and read-capture registers live in `bytemem_ctrl`.

## Test plan
- Reset, then a word store of 0xDEADBEEF to 0x10 → memory writes bytes EF, BE, AD, DE at 0x10–0x13 in cycles 1–4; `d_ack` in cycle 5; an IF read of 0x10 returns 0xDEADBEEF in 2 cycles.
- Half store of 0x1234 to 0x21, then a byte load from 0x22 → writes 34@0x21 and 12@0x22; `d_rdata`=0x00000012 with `d_ack` in cycle 2.
- Word store to 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in that order.
- `if_req` and `d_req` both high continuously → first grant goes to data, then IF, data, IF; each ack pulses for exactly 1 cycle; `mem_wr` is never high during READ.
- `rst` low in cycle 2 of a word store → all outputs 0 immediately; bytes 0–1 are written and bytes 2–3 are not; no ack.
- Requester holds `req` high one cycle past ack → a second, identical transaction starts.
